// File: rtl/modbus_rtu_pkg.sv
// Modbus RTU framer shared constants, FSM encodings and timing helpers.
// t15/t35 return silence thresholds in clk cycles for a given clock and baud.
package modbus_rtu_pkg;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;

   typedef logic [2:0] state_t;

   localparam state_t ST_STARTUP = 3'd0;
   localparam state_t ST_IDLE    = 3'd1;
   localparam state_t ST_RECV    = 3'd2;
   localparam state_t ST_GAP     = 3'd3;
   localparam state_t ST_DISCARD = 3'd4;
   localparam state_t ST_DONE    = 3'd5;

   // Above 19200 baud the character-based timing is replaced by
   // fixed 750 us / 1750 us silences.
   function automatic logic [31:0] t15(
      input longint unsigned clk_hz,
      input longint unsigned baud
   );
      longint unsigned tc;
      tc = (clk_hz * 64'd11) / baud;
      if (baud > 64'd19200)
         return 32'((clk_hz * 64'd750) / 64'd1000000);
      return 32'((tc * 64'd3) / 64'd2);
   endfunction

   function automatic logic [31:0] t35(
      input longint unsigned clk_hz,
      input longint unsigned baud
   );
      longint unsigned tc;
      tc = (clk_hz * 64'd11) / baud;
      if (baud > 64'd19200)
         return 32'((clk_hz * 64'd1750) / 64'd1000000);
      return 32'((tc * 64'd7) / 64'd2);
   endfunction

endpackage

// File: rtl/modbus_rtu_framer_crc16.sv
// CRC-16/MODBUS single-byte update, reflected, LSB first.
// Ports: crc_in running CRC, data next byte, crc_out updated CRC.
module modbus_crc16
   import modbus_rtu_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   always_comb begin
      c = crc_in ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         if (c[0])
            c = (c >> 1) ^ CRC_POLY;
         else
            c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/modbus_rtu_framer.sv
// Modbus RTU receive framer: t1.5/t3.5 silence framing, on-the-fly CRC,
// byte forwarding and a registered end-of-frame status pulse.
// Ports: clk, rst_n (async low); rx_data/rx_valid/rx_enable byte input;
//   byte_data/byte_valid/byte_index forwarded bytes; frame_done strobe with
//   frame_len, crc_ok, err_gap, err_overflow held until next frame_done;
//   frame_count wrapping count of completed frames.
module modbus_rtu_framer
   import modbus_rtu_pkg::*;
#(
   parameter int unsigned ClkFrequency = 12000000,
   parameter int unsigned Baud         = 9600,
   parameter int unsigned MAX_LEN      = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_enable,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic [7:0] byte_index,
   output logic       frame_done,
   output logic [7:0] frame_len,
   output logic       crc_ok,
   output logic       err_gap,
   output logic       err_overflow,
   output logic [7:0] frame_count
);

   localparam logic [31:0] T15 =
      t15(64'(ClkFrequency), 64'(Baud));
   localparam logic [31:0] T35 =
      t35(64'(ClkFrequency), 64'(Baud));
   localparam logic [7:0]  MAX_L = 8'(MAX_LEN);

   state_t      state;
   logic [31:0] timer;
   logic [15:0] crc;
   logic [15:0] crc_sel;
   logic [15:0] crc_nx;
   logic [7:0]  len;
   logic        gap_f;
   logic        ovf_f;
   logic        acc;
   logic        len_full;
   logic        finish;

   assign acc      = rx_valid & rx_enable;
   assign len_full = (len == MAX_L);

   // An accepted byte always wins over an expiring silence timer.
   assign finish = !acc && (timer == T35) &&
                   ((state == ST_GAP) || (state == ST_DISCARD));

   // First byte of a frame seeds the CRC from the init value.
   always_comb begin
      crc_sel = crc;
      if ((state == ST_IDLE) || (state == ST_DONE))
         crc_sel = CRC_INIT;
   end

   modbus_crc16 u_crc (
      .crc_in  (crc_sel),
      .data    (rx_data),
      .crc_out (crc_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_STARTUP;
         timer        <= '0;
         crc          <= CRC_INIT;
         len          <= '0;
         gap_f        <= 1'b0;
         ovf_f        <= 1'b0;
         byte_data    <= '0;
         byte_valid   <= 1'b0;
         byte_index   <= '0;
         frame_done   <= 1'b0;
         frame_len    <= '0;
         crc_ok       <= 1'b0;
         err_gap      <= 1'b0;
         err_overflow <= 1'b0;
         frame_count  <= '0;
      end else begin
         byte_valid <= 1'b0;
         frame_done <= 1'b0;

         if (acc)
            timer <= '0;
         else if (timer != T35)
            timer <= timer + 32'd1;

         case (state)
            ST_STARTUP: begin
               if (!acc && (timer == T35))
                  state <= ST_IDLE;
            end
            ST_IDLE, ST_DONE: begin
               if (acc) begin
                  state      <= ST_RECV;
                  crc        <= crc_nx;
                  len        <= 8'd1;
                  gap_f      <= 1'b0;
                  ovf_f      <= 1'b0;
                  byte_valid <= 1'b1;
                  byte_data  <= rx_data;
                  byte_index <= 8'd0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RECV: begin
               if (acc) begin
                  if (len_full) begin
                     ovf_f <= 1'b1;
                     state <= ST_DISCARD;
                  end else begin
                     crc        <= crc_nx;
                     len        <= len + 8'd1;
                     byte_valid <= 1'b1;
                     byte_data  <= rx_data;
                     byte_index <= len;
                  end
               end else if (timer == T15) begin
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (acc) begin
                  gap_f <= 1'b1;
                  state <= ST_DISCARD;
                  if (len_full)
                     ovf_f <= 1'b1;
                  else
                     len <= len + 8'd1;
               end else if (finish) begin
                  state <= ST_DONE;
               end
            end
            ST_DISCARD: begin
               if (acc) begin
                  if (len_full)
                     ovf_f <= 1'b1;
                  else
                     len <= len + 8'd1;
               end else if (finish) begin
                  state <= ST_DONE;
               end
            end
            default: state <= ST_STARTUP;
         endcase

         if (finish) begin
            frame_done   <= 1'b1;
            frame_len    <= len;
            crc_ok       <= (crc == 16'h0000) && (len >= 8'd4) &&
                            !gap_f && !ovf_f;
            err_gap      <= gap_f;
            err_overflow <= ovf_f;
            frame_count  <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_modbus_rtu_framer.sv
// Self-checking bench for modbus_rtu_framer.
// Scaled clock: 96 kHz at 9600 baud gives T15=165, T35=385 cycles.
module tb_modbus_rtu_framer;

   localparam int unsigned CLK_HZ = 96000;
   localparam int unsigned BAUD   = 9600;
   localparam int unsigned MAXL   = 8;
   localparam int T35 = 385;
   localparam int LAT = 386;

   typedef struct {
      int n;
      int gi;
      int gl;
      int fwd;
      int len;
      bit ok;
      bit gap;
      bit ovf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_enable;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic [7:0] byte_index;
   logic       frame_done;
   logic [7:0] frame_len;
   logic       crc_ok;
   logic       err_gap;
   logic       err_overflow;
   logic [7:0] frame_count;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;
   int cyc = 0;
   int bv_cnt = 0;
   int fd_cnt = 0;
   int fd_cyc = 0;
   logic [7:0] cap_d [64];
   logic [7:0] cap_i [64];
   logic [7:0] fb [6][12];
   vec_t vecs [6];

   always #5 clk = ~clk;

   modbus_rtu_framer #(
      .ClkFrequency (CLK_HZ),
      .Baud         (BAUD),
      .MAX_LEN      (MAXL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_enable    (rx_enable),
      .byte_data    (byte_data),
      .byte_valid   (byte_valid),
      .byte_index   (byte_index),
      .frame_done   (frame_done),
      .frame_len    (frame_len),
      .crc_ok       (crc_ok),
      .err_gap      (err_gap),
      .err_overflow (err_overflow),
      .frame_count  (frame_count)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (byte_valid) begin
         cap_d[bv_cnt[5:0]] <= byte_data;
         cap_i[bv_cnt[5:0]] <= byte_index;
         bv_cnt <= bv_cnt + 1;
      end
      if (frame_done) begin
         fd_cnt <= fd_cnt + 1;
         fd_cyc <= cyc;
      end
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // first=1: byte 0 was already driven by the caller this cycle.
   task automatic run_frame(input int f, input int first);
      int bb;
      int fdb;
      int last;
      int bad;
      bit ok;
      bb  = bv_cnt;
      fdb = fd_cnt;
      for (int j = first; j < vecs[f].n; j++) begin
         if (j == vecs[f].gi) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (vecs[f].gl - 1) @(negedge clk);
         end
         @(negedge clk);
         rx_data  = fb[f][j];
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      last = cyc;
      ok = 1'b0;
      for (int k = 0; k < 2000 && !ok; k++) begin
         @(negedge clk);
         if (fd_cnt != fdb) ok = 1'b1;
      end
      exp_count++;
      check($sformatf("f%0d_done", f), 32'(ok), 32'd1);
      check($sformatf("f%0d_latency", f), fd_cyc - last, LAT);
      check($sformatf("f%0d_nfwd", f), bv_cnt - bb, vecs[f].fwd);
      bad = 0;
      for (int j = 0; j < vecs[f].fwd; j++) begin
         if (cap_d[6'(bb + j)] !== fb[f][j]) bad++;
         if (cap_i[6'(bb + j)] !== 8'(j)) bad++;
      end
      check($sformatf("f%0d_fwd_bad", f), bad, 0);
      check($sformatf("f%0d_len", f), 32'(frame_len), vecs[f].len);
      check($sformatf("f%0d_crc_ok", f), 32'(crc_ok), 32'(vecs[f].ok));
      check($sformatf("f%0d_err_gap", f), 32'(err_gap), 32'(vecs[f].gap));
      check($sformatf("f%0d_err_ovf", f), 32'(err_overflow),
            32'(vecs[f].ovf));
      check($sformatf("f%0d_count", f), 32'(frame_count), exp_count);
   endtask

   initial begin
      int fdb;
      int bb;
      rst_n     = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      rx_enable = 1'b1;

      fb[0] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h84, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
      fb[1] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h84, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};
      fb[2] = '{8'h11, 8'h03, 8'h00, 8'h6B, 8'h00, 8'h03,
                8'h76, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00};
      fb[3] = fb[0];
      fb[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h07, 8'h08, 8'h09, 8'h0A, 8'h00, 8'h00};
      fb[5] = fb[0];
      //          n  gi  gl  fwd len ok gap ovf
      vecs[0] = '{8, -1, 0,   8,  8, 1, 0, 0};
      vecs[1] = '{8, -1, 0,   8,  8, 0, 0, 0};
      vecs[2] = '{8, -1, 0,   8,  8, 1, 0, 0};
      vecs[3] = '{8,  4, 200, 4,  8, 0, 1, 0};
      vecs[4] = '{10, -1, 0,  8,  8, 0, 0, 1};
      vecs[5] = '{3, -1, 0,   3,  3, 0, 0, 0};

      repeat (3) @(negedge clk);
      check("rst_strobes", 32'({byte_valid, frame_done}), 32'd0);
      check("rst_status", 32'({frame_len, crc_ok, err_gap,
                               err_overflow, frame_count}), 32'd0);
      check("rst_byte", 32'({byte_data, byte_index}), 32'd0);
      rst_n = 1'b1;

      repeat (99) @(negedge clk);
      rx_data  = 8'h01;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("startup_fwd", bv_cnt, 0);
      repeat (T35 + 50) @(negedge clk);
      check("startup_done", fd_cnt, 0);

      for (int i = 0; i < 6; i++) run_frame(i, 0);

      rx_enable = 1'b0;
      bb  = bv_cnt;
      fdb = fd_cnt;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         rx_data  = fb[0][j];
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (T35 + 100) @(negedge clk);
      check("rxen_fwd", bv_cnt - bb, 0);
      check("rxen_done", fd_cnt - fdb, 0);
      rx_enable = 1'b1;

      run_frame(0, 0);
      check("done_cycle_fd", 32'(frame_done), 32'd1);
      rx_data  = fb[0][0];
      rx_valid = 1'b1;
      run_frame(0, 1);

      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         rx_data  = fb[0][j];
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_count", 32'(frame_count), 32'd0);
      check("midrst_len", 32'(frame_len), 32'd0);
      rst_n = 1'b1;
      fdb = fd_cnt;
      repeat (T35 + 100) @(negedge clk);
      check("midrst_nodone", fd_cnt - fdb, 0);
      exp_count = 0;
      run_frame(0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
